// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared widths and per-boundary control bundle types for the CPU
//            pipeline stage registers (ID/EX, EX/ME, ME/WB).
// Contents : XLEN, REG_ADDR_W, REG_WRITE_W, MEM_WRITE_W, control bundle
//            typedefs and the derived CTRL_W value for each boundary.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam int XLEN        = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int REG_WRITE_W = 3;
  localparam int MEM_WRITE_W = 4;

  // ME/WB boundary: only what writeback still needs.
  typedef struct packed {
    logic [REG_ADDR_W-1:0]  rd;
    logic [REG_WRITE_W-1:0] reg_write;
    logic                   mem_to_reg;
  } wb_ctrl_t;

  // EX/ME boundary: 14 bits.
  typedef struct packed {
    logic [REG_ADDR_W-1:0]  rd;
    logic [REG_WRITE_W-1:0] reg_write;
    logic                   mem_to_reg;
    logic [MEM_WRITE_W-1:0] mem_write;
    logic                   ld_nextpc;
  } me_ctrl_t;

  // ID/EX boundary: EX/ME bundle plus ALU controls consumed in EX.
  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    me_ctrl_t   me;
  } ex_ctrl_t;

  localparam int EX_CTRL_W = $bits(ex_ctrl_t);
  localparam int ME_CTRL_W = $bits(me_ctrl_t);
  localparam int WB_CTRL_W = $bits(wb_ctrl_t);

endpackage
`default_nettype wire

// File: rtl/pipe_stage_skid_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid_if
// Purpose  : One valid/ready link carrying a payload and a control bundle.
// Ports    : valid, ready, data[DATA_W], ctrl[CTRL_W]
//            master drives valid/data/ctrl and samples ready;
//            slave samples valid/data/ctrl and drives ready.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_stage_skid_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = ME_CTRL_W
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface
`default_nettype wire

// File: rtl/pipe_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : pipe_sat_cnt
// Purpose  : Saturating up-counter with enable and synchronous clear.
// Ports    : clk, clr (sync, wins over en), en, cnt[CNT_W]
// Revision : 1.0 - initial release
// ============================================================================
module pipe_sat_cnt
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Purpose  : Pipeline stage register with valid/ready handshake, a 1-entry
//            skid buffer (in_ready is purely registered) and flush-to-bubble.
// Ports    : clk, rst (sync, active-high), flush,
//            up (slave link: in_valid/in_ready/in_data/in_ctrl),
//            dn (master link: out_valid/out_ready/out_data/out_ctrl),
//            stall_cnt, flush_cnt (only when PIPE_STAGE_PERF_EN is defined).
// Options  : `define PIPE_STAGE_PERF_EN adds saturating stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 96,
  parameter int CTRL_W     = ME_CTRL_W,
  parameter int CLEAR_DATA = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_stage_skid_if.slave  up,
  pipe_stage_skid_if.master dn
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;

  logic up_xfer;
  logic m_load;

  // The skid is only ever occupied while main is full, so "skid empty" is
  // exactly "room for one more" and needs nothing from the downstream side.
  assign up.ready = ~s_valid_q;
  assign up_xfer  = up.valid & ~s_valid_q;
  assign m_load   = ~m_valid_q | dn.ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ctrl_d  = m_ctrl_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_ctrl_d  = s_ctrl_q;

    if (flush) begin
      // Any entry offered this cycle is dropped along with the held ones.
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_ctrl_d  = '0;
      s_ctrl_d  = '0;
      if (CLEAR_DATA != 0) begin
        m_data_d = '0;
        s_data_d = '0;
      end
    end else if (m_load) begin
      if (s_valid_q) begin
        // Skid is older than anything upstream; in_ready was low, so no
        // input can be accepted in the same cycle.
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        m_ctrl_d  = s_ctrl_q;
        s_valid_d = 1'b0;
      end else if (up_xfer) begin
        m_valid_d = 1'b1;
        m_data_d  = up.data;
        m_ctrl_d  = up.ctrl;
      end else begin
        // Bubble: payload and ctrl keep their last value.
        m_valid_d = 1'b0;
      end
    end else if (up_xfer) begin
      s_valid_d = 1'b1;
      s_data_d  = up.data;
      s_ctrl_d  = up.ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_ctrl_q  <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      s_ctrl_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ctrl_q  <= m_ctrl_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      s_ctrl_q  <= s_ctrl_d;
    end
  end

  assign dn.valid = m_valid_q;
  assign dn.data  = m_data_q;
  assign dn.ctrl  = m_ctrl_q;

`ifdef PIPE_STAGE_PERF_EN
  // A flush only counts when it actually throws an entry away.
  pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .en  (m_valid_q & ~dn.ready),
    .cnt (stall_cnt)
  );

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .en  (flush & (m_valid_q | s_valid_q)),
    .cnt (flush_cnt)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_skid
// Purpose  : Self-checking bench for pipe_stage_skid. Two instances share one
//            stimulus stream: u_dut_clr (CLEAR_DATA=1, CNT_W=16) and
//            u_dut_hold (CLEAR_DATA=0, CNT_W=2). The reference is a FIFO of
//            at most two entries. Counter checks exist only when
//            PIPE_STAGE_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int DW    = 96;
  localparam int CW    = ME_CTRL_W;
  localparam int CNT_A = 16;
  localparam int CNT_B = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  always #5 clk = ~clk;

  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) up_a ();
  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) dn_a ();
  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) up_b ();
  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) dn_b ();

  assign up_a.valid = in_valid;
  assign up_a.data  = in_data;
  assign up_a.ctrl  = in_ctrl;
  assign dn_a.ready = out_ready;
  assign up_b.valid = in_valid;
  assign up_b.data  = in_data;
  assign up_b.ctrl  = in_ctrl;
  assign dn_b.ready = out_ready;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_A-1:0] stall_a, flush_a;
  logic [CNT_B-1:0] stall_b, flush_b;
`endif

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1), .CNT_W(CNT_A)) u_dut_clr (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .up    (up_a),
    .dn    (dn_a)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_a),
    .flush_cnt (flush_a)
`endif
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(0), .CNT_W(CNT_B)) u_dut_hold (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .up    (up_b),
    .dn    (dn_b)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_b),
    .flush_cnt (flush_b)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] md_a, md_b;   // visible payload of each instance
  logic [CW-1:0] mc;           // visible ctrl (same for both)
  int unsigned   sc_a, sc_b, fc_a, fc_b;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned sat_inc(input int unsigned x, input int w);
    return (x == ((1 << w) - 1)) ? x : x + 1;
  endfunction

  task automatic model_update(input logic r, input logic f, input logic v,
                              input logic [DW-1:0] d, input logic [CW-1:0] c,
                              input logic ordy);
    int unsigned n;
    n = q.size();
    if (r) begin
      q.delete();
      md_a = '0; md_b = '0; mc = '0;
      sc_a = 0; sc_b = 0; fc_a = 0; fc_b = 0;
      return;
    end
    if (n > 0 && !ordy) begin
      sc_a = sat_inc(sc_a, CNT_A);
      sc_b = sat_inc(sc_b, CNT_B);
    end
    if (f) begin
      if (n > 0) begin
        fc_a = sat_inc(fc_a, CNT_A);
        fc_b = sat_inc(fc_b, CNT_B);
      end
      q.delete();
      mc   = '0;
      md_a = '0;      // md_b keeps its payload
      return;
    end
    if (n > 0 && ordy) void'(q.pop_front());
    if (v && n < 2) q.push_back('{d: d, c: c});
    if (q.size() > 0) begin
      md_a = q[0].d;
      md_b = q[0].d;
      mc   = q[0].c;
    end
  endtask

  task automatic check_all();
    logic ev, er;
    ev = (q.size() > 0);
    er = (q.size() < 2);
    check_eq("out_valid_a", dn_a.valid, ev);
    check_eq("out_valid_b", dn_b.valid, ev);
    check_eq("in_ready_a",  up_a.ready, er);
    check_eq("in_ready_b",  up_b.ready, er);
    check_eq("out_data_a",  dn_a.data,  md_a);
    check_eq("out_data_b",  dn_b.data,  md_b);
    check_eq("out_ctrl_a",  dn_a.ctrl,  mc);
    check_eq("out_ctrl_b",  dn_b.ctrl,  mc);
`ifdef PIPE_STAGE_PERF_EN
    check_eq("stall_cnt_a", stall_a, sc_a);
    check_eq("stall_cnt_b", stall_b, sc_b);
    check_eq("flush_cnt_a", flush_a, fc_a);
    check_eq("flush_cnt_b", flush_b, fc_b);
`endif
  endtask

  // Called at a falling edge: drive, clock, update model, check at next fall.
  task automatic step(input logic r, input logic f, input logic v,
                      input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input logic ordy);
    rst = r; flush = f; in_valid = v; in_data = d; in_ctrl = c; out_ready = ordy;
    @(posedge clk);
    model_update(r, f, v, d, c, ordy);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, ordy);
  endtask

  logic [DW-1:0] val_a, val_b, val_c;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_data = DW'(8'hAB); in_ctrl = CW'(14'h3FFF);
    md_a = '0; md_b = '0; mc = '0;
    sc_a = 0; sc_b = 0; fc_a = 0; fc_b = 0;
    val_a = DW'(96'hA0A0_0000_1111_2222_3333_4444);
    val_b = DW'(96'hB0B0_5555_6666_7777_8888_9999);
    val_c = DW'(96'hC0C0_DEAD_BEEF_0123_4567_89AB);
    @(negedge clk);

    // Reset held 3 cycles with an entry offered.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, DW'(8'hAB), CW'(14'h3FFF), 1'b1);
    check_eq("rst_out_valid", dn_a.valid, 1'b0);
    check_eq("rst_out_ctrl",  dn_a.ctrl,  '0);
    check_eq("rst_in_ready",  up_a.ready, 1'b1);
    idle(1, 1'b1);

    // Streaming 1..4 with out_ready high.
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b0, 1'b1, DW'(i), CW'(i + 16), 1'b1);
      check_eq("stream_data", dn_a.data, DW'(i));
      check_eq("stream_rdy",  up_a.ready, 1'b1);
    end
    idle(2, 1'b1);

    // Back-pressure: A then B, stall 5 cycles, release.
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b1, val_a, CW'(14'h0A1), 1'b1);
    step(1'b0, 1'b0, 1'b1, val_b, CW'(14'h0B2), 1'b0);
    check_eq("bp_in_ready", up_a.ready, 1'b0);
    idle(4, 1'b0);
    check_eq("bp_hold_a", dn_a.data, val_a);
`ifdef PIPE_STAGE_PERF_EN
    check_eq("bp_stall5",   stall_a, 5);
    check_eq("bp_stallsat", stall_b, 3);
`endif
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    check_eq("bp_out_b", dn_a.data, val_b);
    idle(2, 1'b1);

    // Flush with both entries full and C offered.
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b1, val_a, CW'(14'h0A1), 1'b1);
    step(1'b0, 1'b0, 1'b1, val_b, CW'(14'h0B2), 1'b0);
    step(1'b0, 1'b1, 1'b1, val_c, CW'(14'h0C3), 1'b0);
    check_eq("fl_valid",  dn_a.valid, 1'b0);
    check_eq("fl_ctrl",   dn_b.ctrl,  '0);
    check_eq("fl_data_z", dn_a.data,  '0);
    check_eq("fl_data_h", dn_b.data,  val_a);
`ifdef PIPE_STAGE_PERF_EN
    check_eq("fl_cnt1", flush_a, 1);
`endif
    idle(3, 1'b1);

    // Flush on an empty stage.
    step(1'b0, 1'b1, 1'b0, '0, '0, 1'b1);
`ifdef PIPE_STAGE_PERF_EN
    check_eq("fl_empty_cnt", flush_a, 1);
`endif
    check_eq("fl_empty_valid", dn_a.valid, 1'b0);

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      logic r, f, v, o;
      r = ($urandom_range(0, 63) == 0);
      f = ($urandom_range(0, 15) == 0);
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 2) != 0);
      step(r, f, v, DW'({$urandom(), $urandom(), $urandom()}), CW'($urandom()), o);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
